// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus master: turns the PC register's fetch request into a
// single-beat instruction-bus read and hands the word and its flags to IF/ID.
module inst_fetch_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        adel_o,
  output logic        ibe_o,
  output logic [1:0]  fsm_state
);

  // Handshakes: bus_req_o/bus_addr_o stay stable until a cycle with
  // bus_ack_i=1 (ack is ignored while bus_req_o=0); IF/ID takes inst_o and
  // its flags in any cycle with inst_valid_o=1 and stall_i[1]=0.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              adel_q, adel_d;
  logic              ibe_q, ibe_d;
  logic              stallreq;

  logic ack;
  logic aligned;
  logic timeout;
  logic unused_stall;

  assign ack          = bus_ack_i & req_q;
  assign aligned      = (pc_i[1:0] == 2'b00);
  assign timeout      = TO_EN && (cnt_q == TO_LAST);
  assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    adel_d   = adel_q;
    ibe_d    = ibe_q;
    stallreq = 1'b0;

    case (state_q)
      IDLE: begin
        stallreq = ce_i & ~flush_i & aligned;
        if (ce_i && !flush_i) begin
          if (!aligned) begin
            // Misaligned PC never reaches the bus; report it as a finished fetch.
            state_d = DONE;
            inst_d  = '0;
            ipc_d   = pc_i;
            valid_d = 1'b1;
            adel_d  = 1'b1;
            ibe_d   = 1'b0;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            addr_d  = {pc_i[31:2], 2'b00};
            cnt_d   = '0;
          end
        end
      end

      BUSY: begin
        stallreq = 1'b1;
        cnt_d    = cnt_inc;
        if (ack) begin
          req_d = 1'b0;
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            inst_d  = bus_rdata_i;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            adel_d  = 1'b0;
            ibe_d   = 1'b0;
          end
        end else if (flush_i) begin
          // The bus still owes us a beat; keep requesting and throw it away.
          state_d = DRAIN;
        end else if (timeout) begin
          state_d = DONE;
          req_d   = 1'b0;
          inst_d  = '0;
          ipc_d   = addr_q;
          valid_d = 1'b1;
          adel_d  = 1'b0;
          ibe_d   = 1'b1;
        end
      end

      DONE: begin
        if (flush_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (!stall_i[1]) begin
          state_d = IDLE;
          valid_d = 1'b0;
          adel_d  = 1'b0;
          ibe_d   = 1'b0;
        end
      end

      DRAIN: begin
        stallreq = ~flush_i;
        cnt_d    = cnt_inc;
        if (ack || timeout) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
      ibe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
      ibe_q   <= ibe_d;
    end
  end

  assign stallreq_o   = stallreq;
  assign bus_req_o    = req_q;
  assign bus_addr_o   = addr_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = ipc_q;
  assign inst_valid_o = valid_q;
  assign adel_o       = adel_q;
  assign ibe_o        = ibe_q;
  assign fsm_state    = state_q;

endmodule
